obi_shared_mem_responder: RTL and testbench
===========================================

# obi_shared_mem_responder

Multi-port OBI responder that terminates the instruction or data request buses of the NHARTS-core CPU system. It arbitrates among ports round-robin, serves one access per grant from an internal word-addressed memory, and returns rvalid/rdata on the originating port. It sits directly on the core-side obi_req_t/obi_resp_t arrays. It acts as the shared scratch/boot memory for the cores.

## Interface
Parameters:
- NPORTS, 3: number of OBI request ports; matches NHARTS.
- NUM_WORDS, 1024: memory depth in 32-bit words.
- ADDR_BASE, 32'h0000_0000: byte address mapped to word 0.
- WAIT_CYCLES, 0: extra cycles between winning arbitration and gnt (0..15).

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  obi_req_t[NPORTS]  per-port req/we/be/addr/wdata.
- resp_o  out  obi_resp_t[NPORTS]  per-port gnt/rvalid/rdata.
- err_o  out  NPORTS  per-port out-of-range flag, valid with rvalid.

## Operation
- Word index = (addr − ADDR_BASE) >> 2; addr[1:0] ignored. Unsigned subtraction, 32-bit wrap. Index ≥ NUM_WORDS is out of range.
- FSM states:
  - IDLE: select the winner among ports with req=1, searching upward from rr_ptr with wrap. If WAIT_CYCLES=0, assert gnt to the winner in this cycle. Otherwise latch the winner and the counter and go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, go to GRANT. Other ports are not considered.
  - GRANT: assert gnt to the latched winner, then go to IDLE.
- At the gnt edge:
  - rr_ptr ← winner+1 mod NPORTS.
  - Write: bytes with be[i]=1 are updated; other bytes are kept. Out-of-range writes are dropped.
  - Read: the memory word is captured for the response. Out-of-range reads capture 32'hBADC_AB1E.
- Every grant, read or write, produces exactly one rvalid on the granted port. Writes return rdata=0. err_o=1 when the access was out of range.
- A latched winner that drops req before gnt violates protocol. The FSM returns to IDLE without gnt and without rvalid.
- Memory contents are not reset.

## Timing
- Reset values: all gnt=0, rvalid=0, rdata=0, err_o=0, FSM=IDLE, rr_ptr=0.
- gnt is combinational from req_i and state, asserted in the same cycle as req (WAIT_CYCLES=0), or in cycle WAIT_CYCLES+1 after req is first seen.
- rvalid/rdata/err_o are registered, asserted exactly 1 cycle after gnt, for 1 cycle. At most one port has rvalid in any cycle.
- Back-to-back: a new gnt may coincide with the previous rvalid. Throughput is 1 access/cycle at WAIT_CYCLES=0 and 1 per WAIT_CYCLES+1 cycles otherwise.
- Write then read of the same word in the next cycle returns the new data (write-first at the edge).
- All ports requesting continuously: grants rotate 0,1,2,0,… and no port waits more than NPORTS−1 grants.
- Reset asserted mid-transaction: a pending rvalid is dropped. A write already granted stays committed.
- WAIT_CYCLES is checked at elaboration: values above 15 are a fatal error.

## Structure
- obi_req_t/obi_resp_t come from obi_pkg.
- A package obi_mem_resp_pkg holds OOR_RDATA=32'hBADC_AB1E and the FSM state enum.
- Sub-module obi_rr_arbiter (parameter NPORTS): req vector + rr_ptr → onehot grant + index.
- The memory is an inferred reg array with a byte-enable write.

## Test plan
- Single port 0 write addr 0x10, wdata 0xDEADBEEF, be 4'b1111 → gnt same cycle, rvalid next cycle with rdata 0. A read of 0x10 then returns 0xDEADBEEF.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with be 4'b0101 → read returns 0x11BB33DD.
- All 3 ports request reads for 6 consecutive cycles → gnt order 0,1,2,0,1,2; each rvalid 1 cycle later on the matching port only.
- Read at byte address ADDR_BASE+4·NUM_WORDS → rdata 0xBADCAB1E, err_o=1 on that port. A write to the same address leaves memory unchanged.
- WAIT_CYCLES=3, port 1 requests at cycle 0 → gnt at cycle 3, rvalid at cycle 4. Port 2 requesting at cycle 1 is granted no earlier than cycle 7.
- rst_ni asserted in the cycle after gnt of a read → no rvalid. All outputs are 0 while reset is held and on the first cycle after release.

Source files
------------

// File: rtl/obi_mem_resp_pkg.sv
// Constants and FSM encoding for the shared OBI memory responder.
package obi_mem_resp_pkg;

  localparam logic [31:0] OOR_RDATA = 32'hBADC_AB1E;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT
  } state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the core-side buses.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_shared_mem_responder_if.sv
// Bundle of per-port OBI request/response arrays plus error flags.
interface obi_shared_mem_responder_if #(
  parameter int NPORTS = 3
);
  import obi_pkg::*;

  obi_req_t          req_i  [NPORTS];
  obi_resp_t         resp_o [NPORTS];
  logic [NPORTS-1:0] err_o;

  modport master (
    output req_i,
    input  resp_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    output resp_o,
    output err_o
  );
endinterface

// File: rtl/obi_shared_mem_responder_arb.sv
// Round-robin picker: first requester at or above ptr_i, with wrap.
module obi_rr_arbiter #(
  parameter  int NPORTS = 3,
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int i = 0; i < NPORTS; i++) begin
      j = (int'(ptr_i) + i) % NPORTS;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/obi_shared_mem_responder.sv
// Shared OBI scratch/boot memory: round-robin arbitration, one access per gnt.
module obi_shared_mem_responder
  import obi_pkg::*;
  import obi_mem_resp_pkg::*;
#(
  parameter int          NPORTS      = 3,
  parameter int          NUM_WORDS   = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input logic clk_i,
  input logic rst_ni,
  obi_shared_mem_responder_if.slave bus
);

  localparam int          IW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int          MW   = $clog2(NUM_WORDS);
  localparam logic [3:0]  WC   = 4'(WAIT_CYCLES);
  localparam logic [33:0] SPAN = 34'(NUM_WORDS) << 2;

  if (WAIT_CYCLES > 15 || WAIT_CYCLES < 0) begin : g_bad_wait
    $fatal(1, "WAIT_CYCLES must be within 0..15");
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     sel, arb_idx;
  logic [3:0]        cnt_q, cnt_d;
  logic [NPORTS-1:0] reqv, gnt_v, arb_gnt;
  logic [NPORTS-1:0] rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              arb_any, fire, oor;
  obi_req_t          sreq;
  logic [31:0]       offset;
  logic [MW-1:0]     idx;
  logic [31:0]       mem [NUM_WORDS];

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      reqv[p] = bus.req_i[p].req;
    end
  end

  obi_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .req_i (reqv),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sel     = win_q;
    gnt_v   = '0;
    fire    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          if (WC == 4'd0) begin
            fire  = 1'b1;
            sel   = arb_idx;
            gnt_v = arb_gnt;
          end else begin
            win_d   = arb_idx;
            cnt_d   = WC;
            state_d = (WC == 4'd1) ? S_GRANT : S_WAIT;
          end
        end
      end
      // A winner that drops req abandons its slot silently.
      S_WAIT: begin
        if (!reqv[win_q]) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd2) state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = S_IDLE;
        if (reqv[win_q]) begin
          fire         = 1'b1;
          gnt_v[win_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sreq   = bus.req_i[sel];
  assign offset = sreq.addr - ADDR_BASE;
  assign oor    = {2'b00, offset} >= SPAN;
  assign idx    = offset[MW+1:2];

  always_comb begin
    rvalid_d = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    rr_d     = rr_q;
    if (fire) begin
      rvalid_d = gnt_v;
      err_d    = oor;
      if (!sreq.we) rdata_d = oor ? OOR_RDATA : mem[idx];
      rr_d = (sel == IW'(NPORTS - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      cnt_q    <= '0;
      rr_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire && sreq.we && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (sreq.be[b]) mem[idx][8*b +: 8] <= sreq.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      bus.resp_o[p].gnt    = gnt_v[p];
      bus.resp_o[p].rvalid = rvalid_q[p];
      bus.resp_o[p].rdata  = rvalid_q[p] ? rdata_q : '0;
    end
    bus.err_o = rvalid_q & {NPORTS{err_q}};
  end

endmodule

// File: tb/tb_obi_shared_mem_responder.sv
// Directed bench: one zero-wait and one three-wait responder instance.
module tb_obi_shared_mem_responder;
  import obi_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  obi_shared_mem_responder_if #(.NPORTS(3)) bus0 ();
  obi_shared_mem_responder_if #(.NPORTS(3)) bus3 ();

  obi_shared_mem_responder #(
    .NPORTS(3), .NUM_WORDS(1024),
    .ADDR_BASE(32'h0), .WAIT_CYCLES(0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
  );

  obi_shared_mem_responder #(
    .NPORTS(3), .NUM_WORDS(1024),
    .ADDR_BASE(32'h0), .WAIT_CYCLES(3)
  ) u3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  g0, v0, g3, v3;
  logic [31:0] rdor0;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      g0[i] = bus0.resp_o[i].gnt;
      v0[i] = bus0.resp_o[i].rvalid;
      g3[i] = bus3.resp_o[i].gnt;
      v3[i] = bus3.resp_o[i].rvalid;
    end
    rdor0 = bus0.resp_o[0].rdata | bus0.resp_o[1].rdata
          | bus0.resp_o[2].rdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic drv0(input int p, input logic r, input logic we,
                      input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d);
    bus0.req_i[p] = '{req: r, we: we, be: be, addr: a, wdata: d};
  endtask

  task automatic drv3(input int p, input logic r, input logic [31:0] a);
    bus3.req_i[p] = '{req: r, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_gnt"}, 32'(g0), 32'h0);
    chk({tag, "_rvalid"}, 32'(v0), 32'h0);
    chk({tag, "_rdata"}, rdor0, 32'h0);
    chk({tag, "_err"}, 32'(bus0.err_o), 32'h0);
  endtask

  logic [2:0]  eg, ev;
  logic [31:0] ed;
  int          pp;

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drv0(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv3(p, 1'b0, 32'h0);
    end

    cyc(); smp();
    chk_zero0("rst_hold");
    chk("rst_hold_g3", 32'(g3), 32'h0);
    cyc(); rst_n = 1'b1; smp();
    chk_zero0("rst_rel");
    cyc(); smp();
    chk_zero0("rst_rel1");

    // single write then read
    cyc(); drv0(0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF); smp();
    chk("wr_gnt", 32'(g0), 32'h1);
    cyc(); drv0(0, 1, 0, 4'hF, 32'h10, 32'h0); smp();
    chk("wr_rvalid", 32'(v0), 32'h1);
    chk("wr_rdata", bus0.resp_o[0].rdata, 32'h0);
    chk("wr_err", 32'(bus0.err_o), 32'h0);
    chk("rd_gnt_b2b", 32'(g0), 32'h1);
    cyc(); drv0(0, 0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("rd_rvalid", 32'(v0), 32'h1);
    chk("rd_rdata", bus0.resp_o[0].rdata, 32'hDEADBEEF);

    // byte-enable merge
    cyc(); drv0(0, 1, 1, 4'hF, 32'h20, 32'h11223344); smp();
    cyc(); drv0(0, 1, 1, 4'h5, 32'h20, 32'hAABBCCDD); smp();
    cyc(); drv0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drv0(2, 1, 0, 4'hF, 32'h20, 32'h0); smp();
    chk("be_rd_gnt", 32'(g0), 32'h4);
    cyc(); drv0(2, 0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("be_rvalid", 32'(v0), 32'h4);
    chk("be_rdata", bus0.resp_o[2].rdata, 32'h11BB33DD);

    // all ports requesting: rotation 0,1,2,0,1,2
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 0) begin
        drv0(0, 1, 0, 4'hF, 32'h10, 32'h0);
        drv0(1, 1, 0, 4'hF, 32'h20, 32'h0);
        drv0(2, 1, 0, 4'hF, 32'h10, 32'h0);
      end else if (k == 6) begin
        for (int p = 0; p < 3; p++) drv0(p, 0, 0, 4'h0, 32'h0, 32'h0);
      end
      smp();
      if (k < 6) begin
        eg = 3'b001 << (k % 3);
        chk($sformatf("rr_gnt%0d", k), 32'(g0), 32'(eg));
      end
      if (k > 0) begin
        pp = (k - 1) % 3;
        ev = 3'b001 << pp;
        ed = (pp == 1) ? 32'h11BB33DD : 32'hDEADBEEF;
        chk($sformatf("rr_rvalid%0d", k), 32'(v0), 32'(ev));
        chk($sformatf("rr_rdata%0d", k), bus0.resp_o[pp].rdata, ed);
      end
    end

    // last in-range word and out-of-range accesses
    cyc(); drv0(0, 1, 1, 4'hF, 32'h0, 32'hCAFEF00D); smp();
    chk("oor_pre_gnt", 32'(g0), 32'h1);
    cyc(); drv0(0, 1, 1, 4'hF, 32'hFFC, 32'h0BADF00D); smp();
    cyc(); drv0(0, 1, 0, 4'hF, 32'hFFC, 32'h0); smp();
    cyc(); drv0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drv0(1, 1, 0, 4'hF, 32'h1000, 32'h0); smp();
    chk("top_rdata", bus0.resp_o[0].rdata, 32'h0BADF00D);
    chk("top_err", 32'(bus0.err_o), 32'h0);
    chk("oor_rd_gnt", 32'(g0), 32'h2);
    cyc(); drv0(1, 1, 1, 4'hF, 32'h1000, 32'h12345678); smp();
    chk("oor_rd_rvalid", 32'(v0), 32'h2);
    chk("oor_rd_rdata", bus0.resp_o[1].rdata, 32'hBADCAB1E);
    chk("oor_rd_err", 32'(bus0.err_o), 32'h2);
    chk("oor_wr_gnt", 32'(g0), 32'h2);
    cyc(); drv0(1, 0, 0, 4'h0, 32'h0, 32'h0);
    drv0(2, 1, 0, 4'hF, 32'h0, 32'h0); smp();
    chk("oor_wr_rvalid", 32'(v0), 32'h2);
    chk("oor_wr_rdata", bus0.resp_o[1].rdata, 32'h0);
    chk("oor_wr_err", 32'(bus0.err_o), 32'h2);
    cyc(); drv0(2, 0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("oor_keep", bus0.resp_o[2].rdata, 32'hCAFEF00D);
    chk("oor_keep_err", 32'(bus0.err_o), 32'h0);

    // reset right after a read gnt; earlier write must persist
    cyc(); drv0(0, 1, 1, 4'hF, 32'h30, 32'h5A5A5A5A); smp();
    chk("mrst_wr_gnt", 32'(g0), 32'h1);
    cyc(); drv0(0, 1, 0, 4'hF, 32'h10, 32'h0); smp();
    chk("mrst_rd_gnt", 32'(g0), 32'h1);
    cyc(); drv0(0, 0, 0, 4'h0, 32'h0, 32'h0); rst_n = 1'b0; smp();
    chk_zero0("mrst_drop");
    cyc(); smp();
    chk_zero0("mrst_hold");
    cyc(); rst_n = 1'b1; smp();
    chk_zero0("mrst_rel");
    cyc(); drv0(0, 1, 0, 4'hF, 32'h30, 32'h0); smp();
    chk("mrst_rd_gnt2", 32'(g0), 32'h1);
    cyc(); drv0(0, 0, 0, 4'h0, 32'h0, 32'h0); smp();
    chk("mrst_commit", bus0.resp_o[0].rdata, 32'h5A5A5A5A);

    // WAIT_CYCLES=3 timing, fairness and abandoned request
    for (int k = 0; k < 19; k++) begin
      cyc();
      unique case (k)
        0:  drv3(1, 1, 32'h1000);
        1:  drv3(2, 1, 32'h1004);
        4:  drv3(1, 0, 32'h0);
        8:  drv3(2, 0, 32'h0);
        9:  drv3(0, 1, 32'h1000);
        10: drv3(0, 0, 32'h0);
        14: drv3(0, 1, 32'h1008);
        18: drv3(0, 0, 32'h0);
        default: ;
      endcase
      smp();
      eg = (k == 3) ? 3'b010 : (k == 7) ? 3'b100 :
           (k == 17) ? 3'b001 : 3'b000;
      ev = (k == 4) ? 3'b010 : (k == 8) ? 3'b100 :
           (k == 18) ? 3'b001 : 3'b000;
      chk($sformatf("w3_gnt%0d", k), 32'(g3), 32'(eg));
      chk($sformatf("w3_rvalid%0d", k), 32'(v3), 32'(ev));
      chk($sformatf("w3_err%0d", k), 32'(bus3.err_o), 32'(ev));
      if (k == 4)
        chk("w3_rdata", bus3.resp_o[1].rdata, 32'hBADCAB1E);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
